mc_control: RTL and testbench

//  Multi-cycle MIPS control unit; successor to the single-cycle decoder.

---
 rtl/mc_control.sv | 229 ++++++++++++++++++++++
 tb/tb_mc_control.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_control
// Purpose  : Multi-cycle MIPS control unit sequencing FETCH/DECODE/EXEC/MEM/WB
//            with a parametrised data-memory wait and illegal-opcode handling.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control #(
    parameter int MEM_LAT  = 1,
    parameter bit ILL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    input  logic       alu_is0,
    output logic       ir_we,
    output logic       pc_we,
    output logic [2:0] npc_op,
    output logic [2:0] alu_op,
    output logic [1:0] ext_op,
    output logic       grf_we,
    output logic       dm_we,
    output logic [1:0] mux_grf_a3,
    output logic [2:0] mux_grf_wd,
    output logic [1:0] mux_alu_in2,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       illegal
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] c_cnt_last = CW'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP  = 4'd0,
        CL_ADDU = 4'd1,
        CL_SUBU = 4'd2,
        CL_ORI  = 4'd3,
        CL_LW   = 4'd4,
        CL_SW   = 4'd5,
        CL_BEQ  = 4'd6,
        CL_LUI  = 4'd7,
        CL_JAL  = 4'd8,
        CL_JR   = 4'd9,
        CL_ILL  = 4'd10
    } class_t;

    state_t        r_state;
    class_t        r_class;
    logic [CW-1:0] r_cnt;

    class_t     w_dec;
    logic [2:0] w_alu_op;
    logic [1:0] w_ext_op;
    logic [1:0] w_alu_in2;

    always_comb begin
        w_dec = CL_ILL;
        if (op_code == 6'h00) begin
            case (funct)
                6'h21:   w_dec = CL_ADDU;
                6'h23:   w_dec = CL_SUBU;
                6'h00:   w_dec = CL_NOP;
                6'h08:   w_dec = CL_JR;
                default: w_dec = CL_ILL;
            endcase
        end else begin
            case (op_code)
                6'h0d:   w_dec = CL_ORI;
                6'h23:   w_dec = CL_LW;
                6'h2b:   w_dec = CL_SW;
                6'h04:   w_dec = CL_BEQ;
                6'h0f:   w_dec = CL_LUI;
                6'h03:   w_dec = CL_JAL;
                default: w_dec = CL_ILL;
            endcase
        end
    end

    // ALU/extender selects set up in EXEC and held through MEM and WB
    always_comb begin
        w_alu_op  = 3'b000;
        w_ext_op  = 2'b00;
        w_alu_in2 = 2'b00;
        case (r_class)
            CL_SUBU, CL_BEQ: w_alu_op = 3'b001;
            CL_ORI: begin
                w_alu_op  = 3'b010;
                w_alu_in2 = 2'b01;
            end
            CL_LW, CL_SW: begin
                w_ext_op  = 2'b01;
                w_alu_in2 = 2'b01;
            end
            CL_LUI:  w_ext_op = 2'b10;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
            r_class <= CL_NOP;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    r_class <= w_dec;
                    case (w_dec)
                        CL_JAL:         r_state <= S_WB;
                        CL_JR, CL_NOP:  r_state <= S_FETCH;
                        CL_ILL:         r_state <= ILL_HALT ? S_HALT : S_FETCH;
                        default:        r_state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (r_class)
                        CL_LW, CL_SW: begin
                            r_cnt   <= '0;
                            r_state <= S_MEM;
                        end
                        CL_BEQ:  r_state <= S_FETCH;
                        default: r_state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= (r_class == CL_LW) ? S_WB : S_FETCH;
                    end
                end
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        npc_op      = 3'b000;
        alu_op      = 3'b000;
        ext_op      = 2'b00;
        grf_we      = 1'b0;
        dm_we       = 1'b0;
        mux_grf_a3  = 2'b00;
        mux_grf_wd  = 3'b000;
        mux_alu_in2 = 2'b00;
        illegal     = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: ir_we = 1'b1;
                S_DECODE: begin
                    case (w_dec)
                        CL_JR: begin
                            pc_we  = 1'b1;
                            npc_op = 3'b011;
                        end
                        CL_NOP: pc_we = 1'b1;
                        CL_ILL: begin
                            illegal = 1'b1;
                            pc_we   = !ILL_HALT;
                        end
                        default: ;
                    endcase
                end
                S_EXEC: begin
                    alu_op      = w_alu_op;
                    ext_op      = w_ext_op;
                    mux_alu_in2 = w_alu_in2;
                    if (r_class == CL_BEQ) begin
                        pc_we  = 1'b1;
                        npc_op = alu_is0 ? 3'b001 : 3'b000;
                    end
                end
                S_MEM: begin
                    alu_op      = w_alu_op;
                    ext_op      = w_ext_op;
                    mux_alu_in2 = w_alu_in2;
                    // a single store even when the memory wait spans several cycles
                    dm_we       = (r_class == CL_SW) && (r_cnt == '0);
                    pc_we       = (r_class == CL_SW) && (r_cnt == c_cnt_last);
                end
                S_WB: begin
                    alu_op      = w_alu_op;
                    ext_op      = w_ext_op;
                    mux_alu_in2 = w_alu_in2;
                    grf_we      = 1'b1;
                    pc_we       = 1'b1;
                    case (r_class)
                        CL_LW: begin
                            mux_grf_a3 = 2'b01;
                            mux_grf_wd = 3'b001;
                        end
                        CL_LUI: begin
                            mux_grf_a3 = 2'b01;
                            mux_grf_wd = 3'b010;
                        end
                        CL_ORI:  mux_grf_a3 = 2'b01;
                        CL_JAL: begin
                            mux_grf_a3 = 2'b10;
                            mux_grf_wd = 3'b011;
                            npc_op     = 3'b010;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign state      = r_state;
    assign instr_done = pc_we;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control
// Purpose  : Self-checking bench for mc_control: two instances (lat 3/halt,
//            lat 1/nop) against an instruction-step reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control;

    localparam int C_NOP = 0, C_ADDU = 1, C_SUBU = 2, C_ORI = 3, C_LW = 4, C_SW = 5;
    localparam int C_BEQ = 6, C_LUI = 7, C_JAL = 8, C_JR = 9, C_ILL = 10;

    logic       clk = 1'b0;
    logic       r_reset;
    logic [5:0] r_op;
    logic [5:0] r_fn;
    logic       r_z;

    logic       w_ir_we   [2];
    logic       w_pc_we   [2];
    logic [2:0] w_npc_op  [2];
    logic [2:0] w_alu_op  [2];
    logic [1:0] w_ext_op  [2];
    logic       w_grf_we  [2];
    logic       w_dm_we   [2];
    logic [1:0] w_a3      [2];
    logic [2:0] w_wd      [2];
    logic [1:0] w_in2     [2];
    logic [2:0] w_state   [2];
    logic       w_done    [2];
    logic       w_illegal [2];

    always #5 clk = ~clk;

    mc_control #(.MEM_LAT(3), .ILL_HALT(1'b1)) u_dut_a (
        .clk(clk), .reset(r_reset), .op_code(r_op), .funct(r_fn), .alu_is0(r_z),
        .ir_we(w_ir_we[0]), .pc_we(w_pc_we[0]), .npc_op(w_npc_op[0]),
        .alu_op(w_alu_op[0]), .ext_op(w_ext_op[0]), .grf_we(w_grf_we[0]),
        .dm_we(w_dm_we[0]), .mux_grf_a3(w_a3[0]), .mux_grf_wd(w_wd[0]),
        .mux_alu_in2(w_in2[0]), .state(w_state[0]), .instr_done(w_done[0]),
        .illegal(w_illegal[0])
    );

    mc_control #(.MEM_LAT(1), .ILL_HALT(1'b0)) u_dut_b (
        .clk(clk), .reset(r_reset), .op_code(r_op), .funct(r_fn), .alu_is0(r_z),
        .ir_we(w_ir_we[1]), .pc_we(w_pc_we[1]), .npc_op(w_npc_op[1]),
        .alu_op(w_alu_op[1]), .ext_op(w_ext_op[1]), .grf_we(w_grf_we[1]),
        .dm_we(w_dm_we[1]), .mux_grf_a3(w_a3[1]), .mux_grf_wd(w_wd[1]),
        .mux_alu_in2(w_in2[1]), .state(w_state[1]), .instr_done(w_done[1]),
        .illegal(w_illegal[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int halt_cnt = 0;

    // model: cycle index inside the current instruction, its class, halted flag
    int m_k   [2];
    int m_cls [2];
    bit m_halt[2];

    function automatic int lat(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic bit halt_en(input int d);
        return d == 0;
    endfunction

    function automatic int dec(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            case (fn)
                6'h21:   return C_ADDU;
                6'h23:   return C_SUBU;
                6'h00:   return C_NOP;
                6'h08:   return C_JR;
                default: return C_ILL;
            endcase
        end
        case (op)
            6'h0d:   return C_ORI;
            6'h23:   return C_LW;
            6'h2b:   return C_SW;
            6'h04:   return C_BEQ;
            6'h0f:   return C_LUI;
            6'h03:   return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    // total cycles an instruction occupies, FETCH included
    function automatic int ilen(input int c, input int l);
        case (c)
            C_NOP, C_JR, C_ILL: return 2;
            C_BEQ, C_JAL:       return 3;
            C_LW:               return 4 + l;
            C_SW:               return 3 + l;
            default:            return 4;
        endcase
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0h expected=%0h", nm, d, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            int c, k, l, len, ph;
            int e_ir, e_pc, e_npc, e_alu, e_ext, e_grf, e_dm, e_a3, e_wd, e_in2, e_ill;
            k = m_k[d];
            l = lat(d);
            c = (k == 1) ? dec(r_op, r_fn) : m_cls[d];
            len = ilen(c, l);
            if (m_halt[d])                               ph = 5;
            else if (k == 0)                             ph = 0;
            else if (k == 1)                             ph = 1;
            else if (c == C_JAL)                         ph = 4;
            else if (k == 2)                             ph = 2;
            else if ((c == C_LW || c == C_SW) && k < 3 + l) ph = 3;
            else                                         ph = 4;
            e_ir = 0; e_pc = 0; e_npc = 0; e_alu = 0; e_ext = 0; e_grf = 0;
            e_dm = 0; e_a3 = 0; e_wd = 0; e_in2 = 0; e_ill = 0;
            if (!r_reset && !m_halt[d]) begin
                e_ir = (ph == 0);
                e_pc = (k == len - 1) && !(c == C_ILL && halt_en(d));
                if (e_pc != 0)
                    e_npc = (c == C_JR) ? 3 : (c == C_JAL) ? 2 : (c == C_BEQ && r_z) ? 1 : 0;
                if (ph >= 2 && ph <= 4) begin
                    e_alu = (c == C_SUBU || c == C_BEQ) ? 1 : (c == C_ORI) ? 2 : 0;
                    e_ext = (c == C_LW || c == C_SW) ? 1 : (c == C_LUI) ? 2 : 0;
                    e_in2 = (c == C_ORI || c == C_LW || c == C_SW) ? 1 : 0;
                end
                if (ph == 4) begin
                    e_grf = 1;
                    e_a3  = (c == C_LW || c == C_LUI || c == C_ORI) ? 1 : (c == C_JAL) ? 2 : 0;
                    e_wd  = (c == C_LW) ? 1 : (c == C_LUI) ? 2 : (c == C_JAL) ? 3 : 0;
                end
                e_dm  = (c == C_SW && k == 3);
                e_ill = (k == 1 && c == C_ILL);
            end
            chk("state",       d, w_state[d],   ph);
            chk("ir_we",       d, w_ir_we[d],   e_ir);
            chk("pc_we",       d, w_pc_we[d],   e_pc);
            chk("npc_op",      d, w_npc_op[d],  e_npc);
            chk("alu_op",      d, w_alu_op[d],  e_alu);
            chk("ext_op",      d, w_ext_op[d],  e_ext);
            chk("grf_we",      d, w_grf_we[d],  e_grf);
            chk("dm_we",       d, w_dm_we[d],   e_dm);
            chk("mux_grf_a3",  d, w_a3[d],      e_a3);
            chk("mux_grf_wd",  d, w_wd[d],      e_wd);
            chk("mux_alu_in2", d, w_in2[d],     e_in2);
            chk("instr_done",  d, w_done[d],    e_pc);
            chk("illegal",     d, w_illegal[d], e_ill);
        end
    endtask

    task automatic advance();
        for (int d = 0; d < 2; d++) begin
            if (r_reset) begin
                m_k[d]    = 0;
                m_halt[d] = 1'b0;
                m_cls[d]  = C_NOP;
            end else if (!m_halt[d]) begin
                if (m_k[d] == 1) m_cls[d] = dec(r_op, r_fn);
                if (m_k[d] == 1 && m_cls[d] == C_ILL && halt_en(d))
                    m_halt[d] = 1'b1;
                else if (m_k[d] == ilen(m_cls[d], lat(d)) - 1)
                    m_k[d] = 0;
                else
                    m_k[d] = m_k[d] + 1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        advance();
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        r_reset = 1'b1;
        repeat (n) step();
        r_reset = 1'b0;
    endtask

    // literal per-cycle expectations for instance A (MEM_LAT=3, halting)
    task automatic directed(input string nm, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int n, input logic [23:0] st,
                            input logic [7:0] pc, input logic [7:0] dm, input logic [7:0] grf);
        for (int i = 0; i < n; i++) begin
            r_op = op;
            r_fn = fn;
            r_z  = z;
            #2;
            chk({nm, "_state"},  0, w_state[0],  st[i*3 +: 3]);
            chk({nm, "_pc_we"},  0, w_pc_we[0],  pc[i]);
            chk({nm, "_dm_we"},  0, w_dm_we[0],  dm[i]);
            chk({nm, "_grf_we"}, 0, w_grf_we[0], grf[i]);
            step();
        end
    endtask

    initial begin
        r_reset = 1'b1;
        r_op    = '0;
        r_fn    = '0;
        r_z     = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_k[d] = 0; m_cls[d] = C_NOP; m_halt[d] = 1'b0;
        end
        @(posedge clk);
        #1;

        do_reset(2);
        directed("addu", 6'h00, 6'h21, 1'b0, 4, {3'd0,3'd0,3'd0,3'd0,3'd4,3'd2,3'd1,3'd0},
                 8'b0000_1000, 8'b0000_0000, 8'b0000_1000);
        do_reset(1);
        directed("lw", 6'h23, 6'h15, 1'b0, 7, {3'd0,3'd4,3'd3,3'd3,3'd3,3'd2,3'd1,3'd0},
                 8'b0100_0000, 8'b0000_0000, 8'b0100_0000);
        do_reset(1);
        directed("sw", 6'h2b, 6'h00, 1'b1, 6, {3'd0,3'd0,3'd3,3'd3,3'd3,3'd2,3'd1,3'd0},
                 8'b0010_0000, 8'b0000_1000, 8'b0000_0000);
        do_reset(1);
        directed("beq1", 6'h04, 6'h00, 1'b1, 3, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd2,3'd1,3'd0},
                 8'b0000_0100, 8'b0000_0000, 8'b0000_0000);
        directed("beq0", 6'h04, 6'h00, 1'b0, 3, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd2,3'd1,3'd0},
                 8'b0000_0100, 8'b0000_0000, 8'b0000_0000);
        directed("jal", 6'h03, 6'h00, 1'b0, 3, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd4,3'd1,3'd0},
                 8'b0000_0100, 8'b0000_0000, 8'b0000_0100);
        directed("jr", 6'h00, 6'h08, 1'b0, 2, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd1,3'd0},
                 8'b0000_0010, 8'b0000_0000, 8'b0000_0000);
        directed("ill", 6'h3f, 6'h00, 1'b0, 8, {3'd5,3'd5,3'd5,3'd5,3'd5,3'd5,3'd1,3'd0},
                 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
        for (int i = 0; i < 4; i++) begin
            r_op = 6'($urandom);
            r_fn = 6'($urandom);
            #2;
            chk("halt_state", 0, w_state[0], 3'd5);
            step();
        end
        do_reset(1);
        #2;
        chk("post_halt_state", 0, w_state[0], 3'd0);
        chk("post_halt_ir_we", 0, w_ir_we[0], 1'b1);

        for (int n = 0; n < 3000; n++) begin
            halt_cnt = m_halt[0] ? halt_cnt + 1 : 0;
            r_reset  = ($urandom_range(0, 59) == 0) || (halt_cnt > 12);
            r_fn     = 6'($urandom);
            case ($urandom_range(0, 13))
                0:       begin r_op = 6'h00; r_fn = 6'h21; end
                1:       begin r_op = 6'h00; r_fn = 6'h23; end
                2:       begin r_op = 6'h00; r_fn = 6'h00; end
                3:       begin r_op = 6'h00; r_fn = 6'h08; end
                4:       r_op = 6'h0d;
                5, 12:   r_op = 6'h23;
                6, 13:   r_op = 6'h2b;
                7:       r_op = 6'h04;
                8:       r_op = 6'h0f;
                9:       r_op = 6'h03;
                10:      r_op = 6'($urandom);
                default: r_op = 6'h00;
            endcase
            r_z = 1'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
